p_sn: RTL
=========

# p_sn

Parallel-to-serial transmitter for the SD host CMD path, the counterpart of the `s_pn` deserializer. It accepts an `n`-bit word through a load/ready handshake and buffers it in a one-entry holding register. It then shifts the word out MSB-first on a single serial line that idles high. Back-to-back words stream with no idle bit between them, so `s_pn` can be fed directly from this block.

## Interface
- `n`, default 7: word width; legal values n >= 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `enable`  input  1  shift enable; when low, the shifter freezes (handshake still runs).
- `input_n`  input  n  parallel word; sampled on an accepted load.
- `load`  input  1  load request.
- `ready`  output  1  holding register empty, so a load will be accepted.
- `output_1`  output  1  serial data, registered, MSB first; idle value 1.
- `busy`  output  1  shifter currently driving a word.
- `done`  output  1  one-cycle pulse marking the first cycle the LSB of a word is on `output_1`.

## Operation
- Reset values:
  - `output_1`=1, `ready`=1, `busy`=0, `done`=0.
  - Bit counter 0, holding register empty, shift register contents don't-care.
- Load acceptance:
  - A load is accepted on a rising edge where `load`=1 and `ready`=1.
  - `input_n` is captured into the holding register and `ready` drops at that edge.
  - Acceptance does not depend on `enable`.
  - `load` while `ready`=0 is ignored; there is no bypass and the word is not captured.
- Shifter states:
  - IDLE: `busy`=0, `output_1`=1.
  - SHIFT: `busy`=1, bit counter runs 0..n-1.
- IDLE -> SHIFT:
  - Taken on an edge with `enable`=1 and the holding register full.
  - Holding moves to the shifter, `output_1` = MSB, counter = 0, holding empties, `ready` rises.
- SHIFT step: on an edge with `enable`=1 and counter < n-1, shift left, drive the next bit, and increment the counter.
- SHIFT at counter = n-1 (LSB on the line), on an edge with `enable`=1:
  - Holding full: transfer the next word, drive its MSB, counter = 0, stay in SHIFT. There is no gap bit.
  - Holding empty: go to IDLE and drive `output_1`=1.
- `enable`=0 freezes the shifter:
  - `output_1`, counter and state hold.
  - A load into an empty holding register is still accepted.
- `done` behaviour:
  - Registered; asserted for exactly one cycle, on the edge that puts the LSB on `output_1`.
  - If `enable` is low during the LSB cycle, it is not re-asserted.
- Load and transfer on the same edge:
  - The load cannot be accepted because `ready` was 0 before the edge.
  - The freshly emptied holding register shows `ready`=1 from the next cycle.
- Reset mid-word or mid-handshake: the word in flight and the pending word are discarded, and all outputs return to their reset values asynchronously.

## Timing
- All outputs come from flops; there is no combinational path from inputs to outputs.
- Latency, with the shifter idle and `enable`=1:
  - Load accepted at edge k; MSB appears on `output_1` after edge k+1.
  - The LSB appears after edge k+n, with `done` high in that same cycle.
  - `output_1` returns to 1 after edge k+n+1 if no word is pending.
- Throughput: one word per n enabled cycles, continuous, provided each next load is accepted before the current LSB cycle ends.
- Each `enable`=0 cycle stretches the word by one cycle; the bit count per word is always exactly n.

## Test plan
- Reset:
  - Assert `reset` asynchronously mid-cycle: `output_1`=1, `ready`=1, `busy`=0, `done`=0 before the next edge.
  - Release, then idle 5 cycles: `output_1` stays 1.
- Single word:
  - n=7, load 7'b1010011 with `enable`=1.
  - `output_1` = 1,0,1,0,0,1,1 on cycles k+1..k+7.
  - `done` high only in cycle k+7; `output_1`=1 and `busy`=0 from k+8.
- Back-to-back:
  - Load 7'h7F, then load 7'h00 while `ready`=1.
  - Expect 14 contiguous bits (seven 1s, seven 0s) with no idle bit.
  - `done` pulses at bits 7 and 14; a third `load` while `ready`=0 is ignored.
- Enable stall:
  - During 7'b1100101, drop `enable` for 3 cycles while bit index 2 is on the line.
  - That bit holds for 4 cycles total and the sequence is otherwise unchanged.
  - `done` is one pulse, 3 cycles later than unstalled.
- Reset mid-word:
  - Assert `reset` while bit 3 is driven and another word is pending.
  - Both words are dropped and outputs return to reset values.
  - A fresh load of 7'h2A after release transmits 0,1,0,1,0,1,0 correctly.
- Loopback:
  - Connect `output_1` to `s_pn` `input_1`, sharing `clk`, `enable` and `reset`, and send 20 random words.
  - Each `s_pn` `push` presents an `output_n` equal to the corresponding loaded word.

Source files
------------

// File: rtl/p_sn_if.sv
`default_nettype none
// ============================================================================
//  Module      : p_sn_if
//  Description : Load/ready handshake and serial output bundle for p_sn.
//  Revision    : 1.0  initial release
// ============================================================================
interface p_sn_if #(
    parameter int N = 7
);
    logic [N-1:0] input_n;
    logic         load;
    logic         ready;
    logic         output_1;
    logic         busy;
    logic         done;

    modport master (
        output input_n,
        output load,
        input  ready,
        input  output_1,
        input  busy,
        input  done
    );

    modport slave (
        input  input_n,
        input  load,
        output ready,
        output output_1,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/p_sn.sv
`default_nettype none
// ============================================================================
//  Module      : p_sn
//  Description : Parallel-to-serial CMD transmitter, MSB first, idle-high line,
//                one-entry holding register, gapless back-to-back words.
//  Revision    : 1.0  initial release
// ============================================================================
module p_sn #(
    parameter int N = 7
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    p_sn_if.slave     bus
);
    localparam int            c_CW      = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(N - 1);
    localparam logic [c_CW-1:0] c_PENULT = c_CW'(N - 2);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_hold;
    logic [N-1:0]    r_shift;
    logic            r_ready;
    logic            r_out;
    logic            r_done;
    logic            w_take;

    // A pending word moves into the shifter when the line is idle or the LSB
    // is finishing, so consecutive words abut with no idle bit.
    assign w_take = enable && !r_ready &&
                    ((r_state == c_ST_IDLE) || (r_cnt == c_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_out   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // ready was low on a transfer edge, so a same-edge load is never taken
            if (w_take) begin
                r_ready <= 1'b1;
            end else if (bus.load && r_ready) begin
                r_hold  <= bus.input_n;
                r_ready <= 1'b0;
            end

            if (enable) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_take) begin
                            r_shift <= r_hold;
                            r_out   <= r_hold[N-1];
                            r_cnt   <= '0;
                            r_state <= c_ST_SHIFT;
                        end
                    end
                    default: begin
                        if (r_cnt != c_LAST) begin
                            r_shift <= {r_shift[N-2:0], 1'b0};
                            r_out   <= r_shift[N-2];
                            r_cnt   <= r_cnt + c_ONE;
                            r_done  <= (r_cnt == c_PENULT);
                        end else if (w_take) begin
                            r_shift <= r_hold;
                            r_out   <= r_hold[N-1];
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_out   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.output_1 = r_out;
    assign bus.busy     = (r_state == c_ST_SHIFT);
    assign bus.done     = r_done;
endmodule
`default_nettype wire
